// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multi-cycle datapath.
// Holds opcodes, functs, FSM states, ALU ops and status bit indices.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // status = {zero, negative, carry, overflow}
  localparam int ST_Z = 3;
  localparam int ST_N = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational ALU (add/sub/and/or/slt) with status flags.
// Ports: a_i, b_i operands; op_i operation; y_o result; status_o {z,n,c,v}.
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] y_o,
  output logic [3:0]        status_o
);

  localparam int M  = DATA_W - 1;
  localparam int W1 = DATA_W + 1;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] y;
  logic              c;
  logic              v;

  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        y   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a_i[M] == b_i[M]) && (y[M] != a_i[M]);
      end
      ALU_SUB: begin
        // carry-out of a + ~b + 1 is the inverted borrow
        sum = {1'b0, a_i} + {1'b0, ~b_i} + W1'(1);
        y   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a_i[M] != b_i[M]) && (y[M] != a_i[M]);
      end
      ALU_AND: y = a_i & b_i;
      ALU_OR:  y = a_i | b_i;
      ALU_SLT: y = {{(DATA_W-1){1'b0}},
                    $signed(a_i) < $signed(b_i)};
      default: y = '0;
    endcase
    y_o            = y;
    status_o       = '0;
    status_o[ST_Z] = (y == '0);
    status_o[ST_N] = y[M];
    status_o[ST_C] = c;
    status_o[ST_V] = v;
  end

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS-subset core (IDLE/DECODE/EXEC/MEM/WB).
// Ports: instr/valid/ready in, result/status/illegal + pulse out, dbg read.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [3:0]        status,
  output logic              illegal,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int         AW = $clog2(MEM_DEPTH);
  localparam logic [5:0] RC = 6'(REG_COUNT);

  function automatic logic rf_ok(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < RC);
  endfunction

  state_e state_q, state_d;

  logic [31:0]       instr_q;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] mem_q  [MEM_DEPTH];
  logic [DATA_W-1:0] a_q, b_q, st_q;
  logic [DATA_W-1:0] alu_q, load_q;
  logic [3:0]        flags_q;
  logic [DATA_W-1:0] result_q;
  logic [3:0]        status_q;
  logic              illegal_q, valid_q;

  logic [5:0] opc, fn;
  logic [4:0] rs, rt, rd;
  assign opc = instr_q[31:26];
  assign rs  = instr_q[25:21];
  assign rt  = instr_q[20:16];
  assign rd  = instr_q[15:11];
  assign fn  = instr_q[5:0];

  alu_op_e    op;
  logic       use_imm, zext, is_lw, is_sw;
  logic       wr_en, bad;
  logic [4:0] dest;

  always_comb begin
    op      = ALU_ADD;
    use_imm = 1'b0;
    zext    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    wr_en   = 1'b0;
    bad     = 1'b0;
    dest    = rd;
    unique case (1'b1)
      (opc == OP_RTYPE && fn == FN_ADD): wr_en = 1'b1;
      (opc == OP_RTYPE && fn == FN_SUB): begin
        op = ALU_SUB; wr_en = 1'b1;
      end
      (opc == OP_RTYPE && fn == FN_AND): begin
        op = ALU_AND; wr_en = 1'b1;
      end
      (opc == OP_RTYPE && fn == FN_OR): begin
        op = ALU_OR; wr_en = 1'b1;
      end
      (opc == OP_RTYPE && fn == FN_SLT): begin
        op = ALU_SLT; wr_en = 1'b1;
      end
      (opc == OP_ADDI): begin
        use_imm = 1'b1; dest = rt; wr_en = 1'b1;
      end
      (opc == OP_ANDI): begin
        op = ALU_AND; use_imm = 1'b1; zext = 1'b1;
        dest = rt; wr_en = 1'b1;
      end
      (opc == OP_ORI): begin
        op = ALU_OR; use_imm = 1'b1; zext = 1'b1;
        dest = rt; wr_en = 1'b1;
      end
      (opc == OP_LW): begin
        use_imm = 1'b1; is_lw = 1'b1;
        dest = rt; wr_en = 1'b1;
      end
      (opc == OP_SW): begin
        use_imm = 1'b1; is_sw = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  logic [DATA_W-1:0] imm_x, rs_val, rt_val, wb_val;
  logic [DATA_W-1:0] alu_y;
  logic [3:0]        alu_st;
  logic [AW-1:0]     maddr;

  assign imm_x  = zext ? {{(DATA_W-16){1'b0}}, instr_q[15:0]}
                       : {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
  assign rs_val = rf_ok(rs) ? regs_q[rs] : '0;
  assign rt_val = rf_ok(rt) ? regs_q[rt] : '0;
  assign wb_val = is_lw ? load_q : alu_q;
  // word address; upper bits dropped so addresses wrap
  assign maddr  = alu_q[AW+1:2];

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op),
    .y_o      (alu_y),
    .status_o (alu_st)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      st_q      <= '0;
      alu_q     <= '0;
      load_q    <= '0;
      flags_q   <= '0;
      result_q  <= '0;
      status_q  <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == S_IDLE && instr_valid) instr_q <= instr;
      if (state_q == S_DECODE) begin
        a_q  <= rs_val;
        b_q  <= use_imm ? imm_x : rt_val;
        st_q <= rt_val;
      end
      if (state_q == S_EXEC) begin
        alu_q   <= alu_y;
        flags_q <= alu_st;
      end
      if (state_q == S_MEM && is_lw) load_q <= mem_q[maddr];
      if (state_q == S_WB) begin
        valid_q   <= 1'b1;
        illegal_q <= bad;
        result_q  <= bad ? '0 : wb_val;
        status_q  <= bad ? '0 : flags_q;
        if (wr_en && rf_ok(dest)) regs_q[dest] <= wb_val;
      end
    end
  end

  // memory contents survive reset
  always_ff @(posedge clk) begin
    if (state_q == S_MEM && is_sw) mem_q[maddr] <= st_q;
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign status       = status_q;
  assign illegal      = illegal_q;
  assign dbg_data     = rf_ok(dbg_addr) ? regs_q[dbg_addr] : '0;

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: random + directed bench for mc_datapath.
// Compares DUT against an instruction-level reference model.
module tb_mc_datapath;

  localparam int DW = 32;
  localparam int RC = 16;
  localparam int MD = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] result;
  logic          result_valid;
  logic [3:0]    status;
  logic          illegal;
  logic [4:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  mc_datapath #(
    .DATA_W(DW), .REG_COUNT(RC), .MEM_DEPTH(MD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .result(result), .result_valid(result_valid),
    .status(status), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] rf_m  [32];
  logic [31:0] mem_m [MD];

  function automatic logic [31:0] rd_m(input logic [4:0] i);
    if (i == 5'd0 || i >= RC) return 32'd0;
    return rf_m[i];
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // k: 0 add, 1 sub, 2 and, 3 or, 4 slt; returns {z,n,c,v,result}
  function automatic logic [35:0] alu_m(input int k,
    input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c, v;
    longint      s;
    r = 32'd0; c = 1'b0; v = 1'b0; s = 0;
    case (k)
      0: begin
        r = a + b;
        c = (longint'(a) + longint'(b)) > 64'sd4294967295;
        s = longint'($signed(a)) + longint'($signed(b));
      end
      1: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
      end
      2: r = a & b;
      3: r = a | b;
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    if (k < 2) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {r == 32'd0, r[31], c, v, r};
  endfunction

  task automatic model(input logic [31:0] ins,
                       output logic [31:0] res, output logic [3:0] st,
                       output logic ill, output int lat);
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] a, b, sd, se, ze;
    logic [35:0] o;
    int          k, idx;
    bit          wr, ld, sto;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    a = rd_m(rs); b = rd_m(rt); sd = b;
    k = -1; dst = rt; wr = 1; ld = 0; sto = 0; lat = 3;
    case (ins[31:26])
      6'h00: begin
        dst = rd;
        case (ins[5:0])
          6'h20: k = 0;
          6'h22: k = 1;
          6'h24: k = 2;
          6'h25: k = 3;
          6'h2A: k = 4;
          default: k = -1;
        endcase
      end
      6'h08: begin k = 0; b = se; end
      6'h0C: begin k = 2; b = ze; end
      6'h0D: begin k = 3; b = ze; end
      6'h23: begin k = 0; b = se; ld = 1; lat = 4; end
      6'h2B: begin k = 0; b = se; sto = 1; wr = 0; lat = 4; end
      default: k = -1;
    endcase
    if (k < 0) begin
      res = 32'd0; st = 4'd0; ill = 1'b1;
    end else begin
      ill = 1'b0;
      o   = alu_m(k, a, b);
      res = o[31:0];
      st  = o[35:32];
      idx = int'((res >> 2) % MD);
      if (ld)  res = mem_m[idx];
      if (sto) mem_m[idx] = sd;
      if (wr && dst != 5'd0 && dst < RC) rf_m[dst] = res;
    end
  endtask

  task automatic run(input logic [31:0] ins, output logic [31:0] r_o,
                     output logic [3:0] s_o, output logic il_o);
    logic [31:0] er;
    logic [3:0]  es;
    logic        eil;
    int          el, lat, w;
    bit          found;
    model(ins, er, es, eil, el);
    r_o = 32'd0; s_o = 4'd0; il_o = 1'b0;
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
      return;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0; found = 0;
    while (!found && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      found = result_valid;
    end
    chk("latency", found ? lat : 99, el);
    r_o = result; s_o = status; il_o = illegal;
    if (found) begin
      chk("result", result, er);
      chk("status", status, es);
      chk("illegal", illegal, eil);
    end
    @(negedge clk);
    chk("pulse", result_valid, 0);
    dbg_addr = 5'($urandom_range(0, 31));
    #1 chk("dbg", dbg_data, rd_m(dbg_addr));
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      dbg_addr = 5'(i);
      #1 chk(tag, dbg_data, rd_m(5'(i)));
    end
  endtask

  function automatic logic [4:0] rr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] x;
    case ($urandom_range(0, 11))
      0:  return enc_r(6'h20, rr(), rr(), rr());
      1:  return enc_r(6'h22, rr(), rr(), rr());
      2:  return enc_r(6'h24, rr(), rr(), rr());
      3:  return enc_r(6'h25, rr(), rr(), rr());
      4:  return enc_r(6'h2A, rr(), rr(), rr());
      5:  return enc_i(6'h08, rr(), rr(), 16'($urandom));
      6:  return enc_i(6'h0C, rr(), rr(), 16'($urandom));
      7:  return enc_i(6'h0D, rr(), rr(), 16'($urandom));
      8:  return enc_i(6'h23, rr(), rr(), 16'($urandom));
      9:  return enc_i(6'h2B, rr(), rr(), 16'($urandom));
      10: begin
        do x = 6'($urandom);
        while (x == 6'h00 || x == 6'h08 || x == 6'h0C ||
               x == 6'h0D || x == 6'h23 || x == 6'h2B);
        return {x, 26'($urandom)};
      end
      default: begin
        do x = 6'($urandom);
        while (x == 6'h20 || x == 6'h22 || x == 6'h24 ||
               x == 6'h25 || x == 6'h2A);
        return enc_r(x, rr(), rr(), rr());
      end
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  s;
    logic        il;
    logic [31:0] t0, t1, t2, t3;
    int          acc, rv, last, mingap;

    instr = 32'd0; instr_valid = 1'b0; dbg_addr = 5'd0; rst_n = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_status", status, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    #1 chk("rst_ready", instr_ready, 1);
    sweep("rst_regs");

    for (int i = 0; i < MD; i++) begin
      run(enc_i(6'h08, 5'd0, 5'd5, 16'($urandom)), r, s, il);
      run(enc_i(6'h2B, 5'd0, 5'd5, 16'(i * 4)), r, s, il);
    end

    run(enc_i(6'h08, 5'd0, 5'd1, 16'd5), r, s, il);
    run(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD), r, s, il);
    run(enc_r(6'h20, 5'd1, 5'd2, 5'd3), r, s, il);
    chk("add_res", r, 2);
    chk("add_st", s, 4'b0010);
    dbg_addr = 5'd3;
    #1 chk("add_r3", dbg_data, 2);

    run(enc_i(6'h08, 5'd0, 5'd1, 16'h7FFF), r, s, il);
    for (int i = 0; i < 16; i++) begin
      run(enc_r(6'h20, 5'd1, 5'd1, 5'd1), r, s, il);
      run(enc_i(6'h08, 5'd1, 5'd1, 16'd1), r, s, il);
    end
    dbg_addr = 5'd1;
    #1 chk("max_pos", dbg_data, 32'h7FFF_FFFF);
    run(enc_i(6'h08, 5'd1, 5'd1, 16'd1), r, s, il);
    chk("ovf_res", r, 32'h8000_0000);
    chk("ovf_st", s, 4'b0101);

    run(enc_i(6'h08, 5'd0, 5'd1, 16'h00A5), r, s, il);
    run(enc_i(6'h2B, 5'd0, 5'd1, 16'd8), r, s, il);
    chk("sw_addr", r, 8);
    run(enc_i(6'h23, 5'd0, 5'd4, 16'd8), r, s, il);
    chk("lw_res", r, 32'hA5);
    dbg_addr = 5'd4;
    #1 chk("lw_r4", dbg_data, 32'hA5);
    run(enc_i(6'h08, 5'd0, 5'd6, 16'h005A), r, s, il);
    run(enc_i(6'h2B, 5'd0, 5'd6, 16'd8 + 16'(4 * MD)), r, s, il);
    run(enc_i(6'h23, 5'd0, 5'd7, 16'd8), r, s, il);
    chk("alias", r, 32'h5A);

    run({6'h3F, 26'($urandom)}, r, s, il);
    chk("ill_op", il, 1);
    chk("ill_op_res", r, 0);
    run(enc_r(6'h00, 5'd1, 5'd2, 5'd3), r, s, il);
    chk("ill_fn", il, 1);
    chk("ill_fn_st", s, 0);
    sweep("ill_regs");
    run(enc_i(6'h08, 5'd0, 5'd0, 16'd7), r, s, il);
    dbg_addr = 5'd0;
    #1 chk("r0_zero", dbg_data, 0);

    @(negedge clk);
    instr = enc_i(6'h08, 5'd9, 5'd9, 16'd1);
    instr_valid = 1'b1;
    acc = 0; rv = 0; last = -100; mingap = 100;
    for (int c = 0; c < 14; c++) begin
      if (instr_ready) begin
        acc++;
        if (c - last < mingap) mingap = c - last;
        last = c;
      end
      if (result_valid) rv++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (result_valid) rv++;
      @(negedge clk);
    end
    chk("b2b_acc", acc, 4);
    chk("b2b_gap", mingap, 4);
    chk("b2b_pulses", rv, acc);
    for (int i = 0; i < acc; i++) model(instr, t0, s, il, last);
    dbg_addr = 5'd9;
    #1 chk("b2b_r9", dbg_data, rd_m(5'd9));

    run(enc_i(6'h08, 5'd0, 5'd1, 16'h1234), r, s, il);
    @(negedge clk);
    instr = enc_i(6'h2B, 5'd0, 5'd1, 16'd12);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    #1;
    chk("mrst_ready", instr_ready, 1);
    chk("mrst_valid", result_valid, 0);
    sweep("mrst_regs");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mrst_ready1", instr_ready, 1);
    chk("mrst_valid1", result_valid, 0);
    @(negedge clk);
    chk("mrst_valid2", result_valid, 0);
    run(enc_i(6'h23, 5'd0, 5'd8, 16'd12), r, s, il);

    for (int i = 0; i < 150; i++) begin
      t3 = rand_instr();
      run(t3, r, s, il);
    end
    t1 = 32'd0; t2 = 32'd0;
    sweep("final_regs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter DATA_W, 32, datapath and register width; legal range 16..64.
REQ-002 Parameter REG_COUNT, 32, number of architectural registers; legal range 8..32.
REQ-003 Parameter MEM_DEPTH, 64, data-memory depth in DATA_W words; power of two.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 instr  in  32  MIPS-format instruction.
REQ-007 instr_valid  in  1  instr is valid this cycle.
REQ-008 instr_ready  out  1  block can accept an instruction.
REQ-009 result  out  DATA_W  ALU result, or load data for LW.
REQ-010 result_valid  out  1  one-cycle pulse; result, status and illegal are valid.
REQ-011 status  out  4  {zero, negative, carry, overflow} of the ALU operation.
REQ-012 illegal  out  1  retired instruction was unsupported.
REQ-013 dbg_addr  in  5  debug register index.
REQ-014 dbg_data  out  DATA_W  combinational read of register dbg_addr.

Function
REQ-015 FSM states: IDLE, DECODE, EXEC, MEM, WB; the reset state is IDLE.
REQ-016 instr_ready is 1 only in IDLE; acceptance occurs on a rising edge when instr_valid=1 and instr_ready=1; instr is latched at that edge.
REQ-017 Transitions: IDLE->DECODE on acceptance; DECODE->EXEC; EXEC->MEM for LW/SW, EXEC->WB otherwise; MEM->WB; WB->IDLE.
REQ-018 Latency: with acceptance at edge k, result_valid is high in cycle k+3 for ALU and illegal instructions, and in cycle k+4 for LW/SW; exactly one cycle per instruction.
REQ-019 Supported R-type (opcode 0x00) funct codes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A; destination rd.
REQ-020 Supported I-type opcodes: ADDI 0x08, ANDI 0x0C, ORI 0x0D, LW 0x23, SW 0x2B; destination rt.
REQ-021 ADDI, LW and SW sign-extend imm[15:0] to DATA_W; ANDI and ORI zero-extend it.
REQ-022 Arithmetic is DATA_W-bit two's complement with wrap-around; carry is the unsigned carry-out for ADD/ADDI and the inverted borrow for SUB; overflow is signed overflow; both are 0 for logic ops and SLT.
REQ-023 zero = (result == 0); negative = result[DATA_W-1]; for SLT, result is 1 if rs < rt signed, else 0.
REQ-024 Register operands are read in DECODE; the ALU result is registered at the end of EXEC.
REQ-025 Memory word address = ALU_result[log2(MEM_DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo MEM_DEPTH.
REQ-026 LW reads memory in MEM, and result = loaded word; SW writes rt to memory at the end of MEM, and result = byte address.
REQ-027 The register write occurs at the end of WB, except for SW and illegal instructions, which write nothing.
REQ-028 Register 0 reads as 0, and writes to it are discarded; register indices >= REG_COUNT read as 0, and writes to them are discarded; the same rule applies to dbg_addr.
REQ-029 Unsupported opcode or funct: illegal=1 during the result_valid cycle, result=0, status=0, no register or memory side effect.
REQ-030 A write in WB followed by a read of the same register in the next instruction's DECODE returns the new value.

Reset
REQ-031 When rst_n is asserted, the FSM enters IDLE, all registers clear to 0, and result, status, illegal and result_valid all become 0.
REQ-032 Reset mid-instruction aborts the instruction with no further side effects; a memory write already performed is kept; memory contents are not reset.
REQ-033 instr_ready is 1 in the first cycle after rst_n deasserts.

Structure
REQ-034 A shared package mc_pkg holds the opcode and funct constants, the FSM state enum, the ALU operation enum, and the status bit indices.
REQ-035 The ALU is a separate combinational sub-module, mc_alu, parametrised by DATA_W; the register file and memory are inside mc_datapath.

Verification
REQ-036 ADDI r1,r0,5 then ADDI r2,r0,-3 then ADD r3,r1,r2 -> dbg r3=2; status carry=1, zero=0, overflow=0; result_valid 3 cycles after each acceptance.
REQ-037 With DATA_W=32: ADDI r1,r0,0x7FFF, then repeated ADD up to 0x7FFFFFFF, then ADDI r1,r1,1 -> result 0x80000000, overflow=1, negative=1.
REQ-038 SW r1,8(r0) with r1=0xA5, then LW r4,8(r0) -> r4=0xA5; LW result_valid 4 cycles after acceptance; SW result=8; SW with address 8+4*MEM_DEPTH aliases the same word.
REQ-039 opcode 0x3F, and R-type funct 0x00 -> illegal=1, result=0, all registers unchanged; ADDI r0,r0,7 -> dbg r0=0.
REQ-040 instr_valid held high across back-to-back instructions -> instr_ready low outside IDLE; a second instruction is never accepted before the first reaches WB.
REQ-041 rst_n pulsed low during MEM of SW -> FSM in IDLE, r1..r31=0, result_valid not asserted; instr_ready=1 in the next cycle.
